// File: rtl/vec_mem_arbiter.sv
// Three-port fixed-priority arbiter in front of one fixed-latency memory port.
// One transaction is in flight at a time: IDLE -> ACCESS -> WAIT -> RESP.
module vec_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic              we_2,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [ADDR_W-1:0] addr_3,
   input  logic [DATA_W-1:0] wdata_2,
   input  logic [DATA_W-1:0] wdata_3,
   output logic [2:0]        ack,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      RESP
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LAT - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [2:0]        r_winner;
   logic [2:0]        r_ack;
   logic              r_we;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic [2:0]        w_grant;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   // Oldest pipeline stage wins: port 3, then port 2, then port 1.
   always_comb begin
      w_grant = '0;
      w_we    = 1'b0;
      w_addr  = addr_1;
      w_wdata = '0;
      if (req[2]) begin
         w_grant = 3'b100;
         w_we    = 1'b1;
         w_addr  = addr_3;
         w_wdata = wdata_3;
      end else if (req[1]) begin
         w_grant = 3'b010;
         w_we    = we_2;
         w_addr  = addr_2;
         w_wdata = wdata_2;
      end else if (req[0]) begin
         w_grant = 3'b001;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_winner <= '0;
         r_ack    <= '0;
         r_we     <= 1'b0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         r_ack    <= '0;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_winner <= w_grant;
                  r_we     <= w_we;
                  r_addr   <= w_addr;
                  r_wdata  <= w_wdata;
                  // strobes are registered so they line up exactly with ACCESS
                  r_mem_en <= 1'b1;
                  r_mem_we <= w_we;
                  r_state  <= ACCESS;
               end
            end
            ACCESS: begin
               r_cnt   <= LP_CNT_INIT;
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  if (!r_we) begin
                     r_rdata <= mem_rdata;
                  end
                  r_ack   <= r_winner;
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ack       = r_ack;
   assign rdata     = r_rdata;
   assign busy      = (r_state != IDLE);
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign stall     = |(req & ~r_ack);

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: two instances (MEM_LAT 2 and 1) share stimulus; a
// cycle-arithmetic transaction model is checked every cycle plus directed literals.
module tb_vec_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic        we_2;
   logic [31:0] addr_1, addr_2, addr_3, wdata_2, wdata_3;

   logic [2:0]  ack       [2];
   logic [31:0] rdata     [2];
   logic        stall     [2];
   logic        busy      [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      vec_mem_arbiter #(
         .ADDR_W (32),
         .DATA_W (32),
         .MEM_LAT((g == 0) ? 2 : 1)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .req      (req),
         .we_2     (we_2),
         .addr_1   (addr_1),
         .addr_2   (addr_2),
         .addr_3   (addr_3),
         .wdata_2  (wdata_2),
         .wdata_3  (wdata_3),
         .ack      (ack[g]),
         .rdata    (rdata[g]),
         .stall    (stall[g]),
         .busy     (busy[g]),
         .mem_en   (mem_en[g]),
         .mem_we   (mem_we[g]),
         .mem_addr (mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g])
      );
   end

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
      end
   endtask

   // Bench memory: 16 words per instance, read data appears MEM_LAT cycles after mem_en.
   logic [31:0] mem    [2][16];
   int          rd_due [2];
   logic [31:0] rd_val [2];

   // Transaction model: a request sampled while idle in cycle t0 is strobed at t0+1,
   // acked at t0+L+2, and the arbiter is idle again at t0+L+3.
   bit          act    [2];
   int          t0     [2];
   logic [2:0]  win    [2];
   bit          wr     [2];
   logic [31:0] ma     [2];
   logic [31:0] mw     [2];
   logic [31:0] m_rd   [2];

   always @(negedge clk) begin : mon
      int         lat;
      logic [2:0] e_ack;
      bit         e_en;
      bit         e_busy;
      for (int i = 0; i < 2; i++) begin
         lat    = lat_of(i);
         e_en   = act[i] && (cyc == t0[i] + 1);
         e_busy = act[i] && (cyc > t0[i]) && (cyc <= t0[i] + lat + 2);
         e_ack  = (act[i] && (cyc == t0[i] + lat + 2)) ? win[i] : 3'b000;
         if (chk_en) begin
            chk($sformatf("u%0d_ack", i),    32'(ack[i]),    32'(e_ack));
            chk($sformatf("u%0d_busy", i),   32'(busy[i]),   32'(e_busy));
            chk($sformatf("u%0d_mem_en", i), 32'(mem_en[i]), 32'(e_en));
            chk($sformatf("u%0d_mem_we", i), 32'(mem_we[i]), 32'(e_en && wr[i]));
            chk($sformatf("u%0d_rdata", i),  rdata[i],       m_rd[i]);
            chk($sformatf("u%0d_stall", i),  32'(stall[i]),  32'(|(req & ~e_ack)));
            if (e_en) begin
               chk($sformatf("u%0d_mem_addr", i), mem_addr[i], ma[i]);
               if (wr[i]) chk($sformatf("u%0d_mem_wdata", i), mem_wdata[i], mw[i]);
            end
         end
         if (mem_en[i] && mem_we[i]) begin
            mem[i][mem_addr[i][5:2]] = mem_wdata[i];
         end else if (mem_en[i]) begin
            rd_due[i] = cyc + lat;
            rd_val[i] = mem[i][mem_addr[i][5:2]];
         end
         if (rst) begin
            act[i]  = 1'b0;
            m_rd[i] = '0;
         end else begin
            if (act[i] && !wr[i] && (cyc == t0[i] + 1 + lat)) m_rd[i] = mem[i][ma[i][5:2]];
            if (act[i] && (cyc == t0[i] + lat + 2)) begin
               act[i] = 1'b0;
            end else if (!act[i] && (req != 3'b000)) begin
               act[i] = 1'b1;
               t0[i]  = cyc;
               if (req[2]) begin
                  win[i] = 3'b100; wr[i] = 1'b1; ma[i] = addr_3; mw[i] = wdata_3;
               end else if (req[1]) begin
                  win[i] = 3'b010; wr[i] = we_2; ma[i] = addr_2; mw[i] = wdata_2;
               end else begin
                  win[i] = 3'b001; wr[i] = 1'b0; ma[i] = addr_1; mw[i] = '0;
               end
            end
         end
      end
      if (rst) chk_en = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         mem_rdata[i] = (cyc == rd_due[i]) ? rd_val[i] : (32'hBAD0_0000 ^ 32'(cyc * 7 + i));
      end
   endtask

   task automatic idle(input int n);
      req = 3'b000;
      repeat (n) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 16; w++) mem[i][w] = 32'h1000_0000 + 32'(w);
         mem[i][4]    = 32'hDEAD_BEEF;
         rd_due[i]    = -1;
         rd_val[i]    = '0;
         act[i]       = 1'b0;
         t0[i]        = 0;
         win[i]       = '0;
         wr[i]        = 1'b0;
         ma[i]        = '0;
         mw[i]        = '0;
         m_rd[i]      = '0;
         mem_rdata[i] = '0;
      end
      rst = 1'b1; req = 3'b000; we_2 = 1'b0;
      addr_1 = '0; addr_2 = '0; addr_3 = '0; wdata_2 = '0; wdata_3 = '0;
      tick();
      tick();
      #1;
      chk("reset_ack",    32'(ack[0]),    32'h0);
      chk("reset_busy",   32'(busy[0]),   32'h0);
      chk("reset_mem_en", 32'(mem_en[0]), 32'h0);
      chk("reset_rdata",  rdata[0],       32'h0);
      rst = 1'b0;
      idle(3);

      // Port-1 read of 0x10 returning DEADBEEF
      tick();
      req = 3'b001; addr_1 = 32'h10;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) tick();
         #1;
         chk("A_stall", 32'(stall[0]), 32'(k <= 3));
         if (k == 1) begin
            chk("A_mem_en",   32'(mem_en[0]), 32'h1);
            chk("A_mem_we",   32'(mem_we[0]), 32'h0);
            chk("A_mem_addr", mem_addr[0],    32'h10);
         end
         if (k == 4) begin
            chk("A_ack",   32'(ack[0]), 32'h1);
            chk("A_rdata", rdata[0],    32'hDEAD_BEEF);
         end
      end
      idle(6);

      // All three ports at once, each dropping req the cycle after its ack
      tick();
      req = 3'b111; we_2 = 1'b0; addr_1 = 32'h10; addr_2 = 32'h20;
      addr_3 = 32'h30; wdata_3 = 32'hCAFE_F00D;
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) tick();
         if (k == 5)  req[2] = 1'b0;
         if (k == 10) req[1] = 1'b0;
         if (k == 15) req[0] = 1'b0;
         #1;
         chk("B_busy", 32'(busy[0]), 32'(!(k == 0 || k == 5 || k == 10 || k == 15)));
         if (k == 4) chk("B_ack_p3", 32'(ack[0]), 32'h4);
         if (k == 9) begin
            chk("B_ack_p2",   32'(ack[0]), 32'h2);
            chk("B_rdata_p2", rdata[0],    32'h1000_0008);
         end
         if (k == 14) begin
            chk("B_ack_p1",   32'(ack[0]), 32'h1);
            chk("B_rdata_p1", rdata[0],    32'hDEAD_BEEF);
         end
      end
      idle(6);

      // Port-2 write; operands disturbed after sampling must not leak through
      tick();
      req = 3'b010; we_2 = 1'b1; addr_2 = 32'h40; wdata_2 = 32'h1234_5678;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) tick();
         if (k == 1) begin
            we_2 = 1'b0; addr_2 = 32'h44; wdata_2 = '0;
         end
         #1;
         if (k == 1) begin
            chk("C_mem_en",    32'(mem_en[0]), 32'h1);
            chk("C_mem_we",    32'(mem_we[0]), 32'h1);
            chk("C_mem_addr",  mem_addr[0],    32'h40);
            chk("C_mem_wdata", mem_wdata[0],   32'h1234_5678);
         end
         if (k == 4) begin
            chk("C_ack",   32'(ack[0]), 32'h2);
            chk("C_rdata", rdata[0],    32'hDEAD_BEEF);
         end
      end
      idle(6);

      // Reset in cycle 2 of a port-1 read aborts it with no ack
      tick();
      req = 3'b001; addr_1 = 32'h10;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; req = 3'b000;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("D_u%0d_ack", i),    32'(ack[i]),    32'h0);
         chk($sformatf("D_u%0d_rdata", i),  rdata[i],       32'h0);
         chk($sformatf("D_u%0d_mem_en", i), 32'(mem_en[i]), 32'h0);
         chk($sformatf("D_u%0d_mem_we", i), 32'(mem_we[i]), 32'h0);
         chk($sformatf("D_u%0d_busy", i),   32'(busy[i]),   32'h0);
      end
      for (int k = 4; k <= 10; k++) begin
         tick();
         #1;
         chk("D_noack_u0", 32'(ack[0]), 32'h0);
         chk("D_noack_u1", 32'(ack[1]), 32'h0);
      end
      idle(3);

      // Port-3 write with req dropped at cycle 2; MEM_LAT=1 instance is u1
      tick();
      req = 3'b100; addr_3 = 32'h50; wdata_3 = 32'hA5A5_0038;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 2) req = 3'b000;
         #1;
         if (k == 1) begin
            chk("E_mem_en",   32'(mem_en[1]), 32'h1);
            chk("E_mem_we",   32'(mem_we[1]), 32'h1);
            chk("E_mem_addr", mem_addr[1],    32'h50);
         end
         if (k == 3) begin
            chk("E_ack_u1", 32'(ack[1]), 32'h4);
            chk("E_ack_u0", 32'(ack[0]), 32'h0);
         end
         if (k == 4) begin
            chk("E_busy_u1", 32'(busy[1]), 32'h0);
            chk("E_ack_u0",  32'(ack[0]),  32'h4);
         end
         if (k >= 4) chk("E_no_en_u1", 32'(mem_en[1]), 32'h0);
      end
      idle(4);

      // Read back the word written by port 2
      tick();
      req = 3'b010; we_2 = 1'b0; addr_2 = 32'h40;
      for (int k = 1; k <= 4; k++) begin
         tick();
         #1;
         if (k == 4) begin
            chk("F_ack",   32'(ack[0]), 32'h2);
            chk("F_rdata", rdata[0],    32'h1234_5678);
         end
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
